// File: rtl/spw_timecode_monitor.sv
// spw_timecode_monitor: Avalon-MM slave capturing SpaceWire time-codes.
// Each tick_in strobe (while enabled) pushes the 8-bit time-code into a
// 4-deep FIFO read through the DATA register. The monitor flags overflow
// and breaks in the 6-bit count sequence, and drives a level interrupt.
//
// Optional feature macro: SPW_TIMECODE_WATCHDOG_EN
//   defined   -> tick watchdog down-counter plus RELOAD register at addr 3
//   undefined -> no watchdog, addr 3 reads 0, STATUS[4] is constant 0
//
// Bus handshake: read and write are single-cycle Avalon strobes with no
// wait states. A read is sampled at a rising edge and readdata holds the
// result from the following cycle on. A write takes effect at the same edge
// and is visible from the next cycle on.
module spw_timecode_monitor #(
  parameter logic [15:0] TIMEOUT_DEFAULT = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic [7:0]  in_port,
  input  logic        tick_in
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_RELOAD  = 2'd3;

  // FIFO storage and pointers
  logic [7:0]  mem [0:3];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  level;
  logic        empty;
  logic        full;

  // sticky flags, error counter, control
  logic        overflow;
  logic        seq_err;
  logic        timeout;
  logic [7:0]  err_cnt;
  logic [2:0]  ctrl;
  logic        enable;

  // sequence tracking
  logic        have_last;
  logic [5:0]  last;
  logic [5:0]  next_count;

  // per-cycle events
  logic        pop;
  logic        push_req;
  logic        push;
  logic        drop;
  logic        seq_hit;
  logic        status_wr;
  logic        cnt_clr;
  logic [31:0] rd_data;
  logic [31:0] status_word;
  logic [31:0] reload_word;

  assign enable     = ctrl[0];
  assign empty      = (level == 3'd0);
  assign full       = (level == 3'd4);
  assign next_count = last + 6'd1;

  assign pop       = read && (address == ADDR_DATA) && !empty;
  assign push_req  = tick_in && enable;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign seq_hit   = push_req && have_last && (in_port[5:0] != next_count);
  assign status_wr = write && (address == ADDR_STATUS);
  assign cnt_clr   = status_wr && writedata[31];

  // FIFO pointer and fill-level bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      level  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      level <= level + 3'd1;
      else if (pop && !push) level <= level - 3'd1;
    end
  end

  // FIFO data array; contents are meaningless while level says empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_port;
  end

  // Sticky error flags and saturating sequence-error count; set beats clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      seq_err  <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      if (drop)                         overflow <= 1'b1;
      else if (status_wr && writedata[2]) overflow <= 1'b0;

      if (seq_hit)                      seq_err <= 1'b1;
      else if (status_wr && writedata[3]) seq_err <= 1'b0;

      if (cnt_clr)                          err_cnt <= seq_hit ? 8'd1 : 8'd0;
      else if (seq_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Last seen count; the first tick after enabling only primes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_last <= 1'b0;
      last      <= 6'd0;
    end else if (!enable) begin
      have_last <= 1'b0;
    end else if (push_req) begin
      have_last <= 1'b1;
      last      <= in_port[5:0];
    end
  end

  // CONTROL register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= 3'd0;
    end else if (write && (address == ADDR_CONTROL)) begin
      ctrl <= writedata[2:0];
    end
  end

`ifdef SPW_TIMECODE_WATCHDOG_EN
  logic [15:0] reload;
  logic [15:0] wd_cnt;
  logic        enable_q;
  logic        wd_load;
  logic        wd_expire;
  logic        unused_wdata;

  assign wd_load   = push_req || (enable && !enable_q);
  // Decrementing from 1 reaches 0, which fires and reloads in one step.
  assign wd_expire = !wd_load && enable && (reload != 16'd0) && (wd_cnt <= 16'd1);
  assign reload_word  = {16'd0, reload};
  assign unused_wdata = ^writedata[30:16];

  // RELOAD register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload <= TIMEOUT_DEFAULT;
    end else if (write && (address == ADDR_RELOAD)) begin
      reload <= writedata[15:0];
    end
  end

  // Watchdog down-counter, restarted by ticks and by the enable rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt   <= TIMEOUT_DEFAULT;
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable;
      if (wd_load || wd_expire)                   wd_cnt <= reload;
      else if (enable && (reload != 16'd0))       wd_cnt <= wd_cnt - 16'd1;
    end
  end

  // Sticky timeout flag; set beats clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (wd_expire) begin
      timeout <= 1'b1;
    end else if (status_wr && writedata[4]) begin
      timeout <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign timeout     = 1'b0;
  assign reload_word = 32'd0;
  assign unused_cfg  = ^{writedata[30:5], TIMEOUT_DEFAULT};
`endif

  assign status_word = {16'd0, err_cnt, level, timeout, seq_err, overflow, full, empty};

  // Register read multiplexer; an empty DATA read returns all zeros
  always_comb begin
    rd_data = 32'd0;
    case (address)
      ADDR_DATA:    rd_data = pop ? {23'd0, 1'b1, mem[rd_ptr]} : 32'd0;
      ADDR_STATUS:  rd_data = status_word;
      ADDR_CONTROL: rd_data = {29'd0, ctrl};
      ADDR_RELOAD:  rd_data = reload_word;
      default:      rd_data = 32'd0;
    endcase
  end

  // Registered read data, updated only on a read strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 32'd0;
    end else if (read) begin
      readdata <= rd_data;
    end
  end

  // Registered level interrupt from the current flag state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (ctrl[1] && !empty) || (ctrl[2] && (overflow || seq_err || timeout));
    end
  end

endmodule

// File: tb/tb_spw_timecode_monitor.sv
// Testbench for spw_timecode_monitor: table-driven directed vectors,
// hand-written multi-cycle sequences and a randomized phase checked against
// a queue-based reference model. Honors SPW_TIMECODE_WATCHDOG_EN.
module tb_spw_timecode_monitor;

  localparam logic [15:0] TDEF = 16'd50000;
`ifdef SPW_TIMECODE_WATCHDOG_EN
  localparam logic [31:0] EXP_RELOAD = {16'd0, TDEF};
`else
  localparam logic [31:0] EXP_RELOAD = 32'd0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  in_port;
  logic        tick_in;

  spw_timecode_monitor #(.TIMEOUT_DEFAULT(TDEF)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .in_port(in_port), .tick_in(tick_in)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  m_q[$];
  logic        m_ovf, m_seq, m_to, m_have_last, m_irq;
  int          m_cnt, m_last;
  logic [2:0]  m_ctrl;
  logic [15:0] m_reload;
  logic [31:0] exp_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    int n;
    n = m_q.size();
    return {16'd0, 8'(m_cnt), 3'(n), m_to, m_seq, m_ovf, (n == 4), (n == 0)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_seq = 0; m_to = 0; m_have_last = 0; m_irq = 0;
    m_cnt = 0; m_last = 0; m_ctrl = 3'd0; m_reload = EXP_RELOAD[15:0];
    exp_rd = 32'd0;
  endtask

  // driver: one bus/tick cycle; the model advances by the same cycle
  task automatic step(input logic tk, input logic [7:0] code, input logic rd,
                      input logic wr, input logic [1:0] addr, input logic [31:0] wdata);
    logic pop, push_req, ovf_set, seq_set;
    tick_in = tk; in_port = code; read = rd; write = wr;
    address = addr; writedata = wdata;
    pop = rd && (addr == 2'd0) && (m_q.size() > 0);
    if (rd) begin
      case (addr)
        2'd0: exp_rd = pop ? {23'd0, 1'b1, m_q[0]} : 32'd0;
        2'd1: exp_rd = model_status();
        2'd2: exp_rd = {29'd0, m_ctrl};
        default: exp_rd = {16'd0, m_reload};
      endcase
    end
    m_irq = (m_ctrl[1] && m_q.size() > 0) || (m_ctrl[2] && (m_ovf || m_seq || m_to));
    push_req = tk && m_ctrl[0];
    ovf_set = 0;
    seq_set = 0;
    if (pop) void'(m_q.pop_front());
    if (push_req) begin
      if (m_q.size() < 4) m_q.push_back(code);
      else ovf_set = 1;
      if (m_have_last && int'(code[5:0]) != (m_last + 1) % 64) seq_set = 1;
      m_have_last = 1;
      m_last = int'(code[5:0]);
    end
    if (!m_ctrl[0]) m_have_last = 0;
    if (wr && addr == 2'd1) begin
      if (wdata[2]) m_ovf = 0;
      if (wdata[3]) m_seq = 0;
      if (wdata[4]) m_to = 0;
      if (wdata[31]) m_cnt = 0;
    end
    if (wr && addr == 2'd2) m_ctrl = wdata[2:0];
`ifdef SPW_TIMECODE_WATCHDOG_EN
    if (wr && addr == 2'd3) m_reload = wdata[15:0];
`endif
    if (ovf_set) m_ovf = 1;
    if (seq_set) begin
      m_seq = 1;
      if (m_cnt < 255) m_cnt++;
    end
    @(posedge clk);
    #1;
    tick_in = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b0, 8'h00, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b0, 8'h00, 1'b0, 1'b1, a, d);
  endtask

  task automatic tk(input logic [7:0] c);
    step(1'b1, c, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick_in = 1'b0; read = 1'b0; write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // vector table
  typedef struct {
    logic        tk;
    logic [7:0]  code;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic t, input logic [7:0] c, input logic r, input logic w,
                              input logic [1:0] a, input logic [31:0] d, input logic k,
                              input logic [31:0] e);
    vec_t v;
    v.tk = t; v.code = c; v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.chk = k; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic void add_t(input logic [7:0] c);
    add(1'b1, c, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
  endfunction

  function automatic void add_w(input logic [1:0] a, input logic [31:0] d);
    add(1'b0, 8'h00, 1'b0, 1'b1, a, d, 1'b0, 32'd0);
  endfunction

  function automatic void add_r(input logic [1:0] a, input logic [31:0] e);
    add(1'b0, 8'h00, 1'b1, 1'b0, a, 32'd0, 1'b1, e);
  endfunction

  initial begin
    int found;
    logic irq_prev, irq_at, prev_at;
    logic t;
    logic [7:0] code;
    logic [5:0] sent;
    logic r, w;
    logic [1:0] a;
    logic [31:0] d;
    int sel;

    reset = 1'b1; address = 2'd0; read = 1'b0; write = 1'b0;
    writedata = 32'd0; in_port = 8'd0; tick_in = 1'b0;
    do_reset();

    // reset state
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd(2'd1); check("rst_status", readdata, 32'h1);
    rd(2'd2); check("rst_control", readdata, 32'd0);
    rd(2'd3); check("rst_reload", readdata, EXP_RELOAD);

    // basic capture, level latency, pops and empty read
    add_w(2'd2, 32'h1);
    add_t(8'h05);
    add_r(2'd1, 32'h20);
    add_t(8'h06);
    add_t(8'h07);
    add_r(2'd0, 32'h105);
    add_r(2'd0, 32'h106);
    add_r(2'd0, 32'h107);
    add_r(2'd0, 32'h000);
    add_r(2'd1, 32'h1);
    // overflow: 0x07 -> 0x10 is one sequence error
    for (int i = 0; i < 6; i++) add_t(8'h10 + 8'(i));
    add_r(2'd1, 32'h18E);
    for (int i = 0; i < 4; i++) add_r(2'd0, 32'h110 + 32'(i));
    add_r(2'd0, 32'h0);
    add_w(2'd1, 32'h8000_001C);
    add_r(2'd1, 32'h1);
    // sequence check with legal wrap after re-enable
    add_w(2'd2, 32'h0);
    add_w(2'd2, 32'h1);
    add_t(8'h3E); add_t(8'h3F); add_t(8'h00); add_t(8'h02);
    add_r(2'd1, 32'h18A);
    add_w(2'd1, 32'h8000_0008);
    add_r(2'd1, 32'h82);
    add_r(2'd0, 32'h13E); add_r(2'd0, 32'h13F);
    add_r(2'd0, 32'h100); add_r(2'd0, 32'h102);

    foreach (tbl[i]) begin
      step(tbl[i].tk, tbl[i].code, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].chk) check($sformatf("vec%0d", i), readdata, tbl[i].exp);
    end

    // full FIFO with coincident tick and pop
    tk(8'h03); tk(8'h04); tk(8'h05); tk(8'h06);
    rd(2'd1); check("full_status", readdata, 32'h82);
    step(1'b1, 8'h07, 1'b1, 1'b0, 2'd0, 32'd0);
    check("full_pop_push", readdata, 32'h103);
    rd(2'd1); check("full_after", readdata, 32'h82);
    for (int i = 0; i < 4; i++) begin
      rd(2'd0); check("full_drain", readdata, 32'h104 + 32'(i));
    end
    rd(2'd1); check("full_empty", readdata, 32'h1);

`ifdef SPW_TIMECODE_WATCHDOG_EN
    // watchdog timeout and irq
    wr(2'd3, 32'd10);
    wr(2'd2, 32'd0);
    wr(2'd2, 32'd5);
    found = 0; irq_at = 1'b0; prev_at = 1'b1;
    for (int k = 1; k <= 30 && found == 0; k++) begin
      irq_prev = irq;
      rd(2'd1);
      if (readdata[4]) begin
        found = k; irq_at = irq; prev_at = irq_prev;
      end
    end
    check("wd_fire_cycle", {31'd0, (found >= 11 && found <= 12)}, 32'd1);
    check("wd_irq_before", {31'd0, prev_at}, 32'd0);
    check("wd_irq_after", {31'd0, irq_at}, 32'd1);
    wr(2'd3, 32'd0);
    wr(2'd1, 32'h10);
    idle();
    rd(2'd1);
    check("wd_w1c", {31'd0, readdata[4]}, 32'd0);
    check("wd_irq_drop", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'h1);
`else
    wr(2'd3, 32'h1234);
    rd(2'd3); check("reload_absent", readdata, 32'd0);
`endif

    // counter saturation, then clear coincident with an error
    for (int i = 0; i < 260; i++) tk(8'h00);
    rd(2'd1); check("cnt_sat", {24'd0, readdata[15:8]}, 32'hFF);
    step(1'b1, 8'h00, 1'b0, 1'b1, 2'd1, 32'h8000_0008);
    rd(2'd1); check("cnt_clr_inc", readdata, 32'h18E);
    wr(2'd1, 32'h8000_001C);
    for (int i = 0; i < 4; i++) rd(2'd0);

    // reset mid-operation with entries buffered and irq high
    wr(2'd2, 32'h3);
    tk(8'h08); tk(8'h09); tk(8'h0A);
    idle(); idle();
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    model_reset();
    rd(2'd1); check("mid_rst_status", readdata, 32'h1);
    rd(2'd2); check("mid_rst_control", readdata, 32'd0);
    rd(2'd3); check("mid_rst_reload", readdata, EXP_RELOAD);
    rd(2'd0); check("mid_rst_data", readdata, 32'd0);

    // randomized phase against the reference model
    do_reset();
    wr(2'd3, 32'd0);
    wr(2'd2, 32'h7);
    sent = 6'd0;
    for (int n = 0; n < 3000; n++) begin
      t = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 99) < 80) code = {2'($urandom_range(0, 3)), sent + 6'd1};
      else code = 8'($urandom);
      if (t) sent = code[5:0];
      r = 1'b0; w = 1'b0; a = 2'd0; d = 32'd0;
      sel = $urandom_range(0, 99);
      if (sel < 35) begin
        r = 1'b1;
      end else if (sel < 50) begin
        r = 1'b1; a = 2'($urandom_range(1, 3));
      end else if (sel < 56) begin
        w = 1'b1; a = 2'd1;
        d = {1'($urandom_range(0, 1)), 26'd0, 3'($urandom_range(0, 7)), 2'd0};
      end else if (sel < 59) begin
        w = 1'b1; a = 2'd2;
        d = {29'd0, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) != 0)};
      end else if (sel < 60) begin
        w = 1'b1; a = 2'd3;
`ifndef SPW_TIMECODE_WATCHDOG_EN
        d = $urandom;
`endif
      end
      step(t, code, r, w, a, d);
      if (r) check("rand_rd", readdata, exp_rd);
      check("rand_irq", {31'd0, irq}, {31'd0, m_irq});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spw_timecode_monitor.md
# spw_timecode_monitor

Avalon-MM slave that captures SpaceWire time-codes from the link's 8-bit time-code output, buffers them in a 4-entry FIFO and checks sequence continuity. It also supervises tick arrival with a programmable watchdog and raises a level interrupt to the Nios II. It sits between the SpaceWire codec's tick_out/time_out pins and the system interconnect. It replaces the plain sampled input port with event-driven capture, so no time-code is lost between CPU polls.

## Interface
- TIMEOUT_DEFAULT, 16'd50000, reset value of the watchdog reload register (clk cycles).
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  register select.
- read  input  1  Avalon read strobe.
- write  input  1  Avalon write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt, registered.
- in_port  input  8  time-code: [7:6] control flags, [5:0] count.
- tick_in  input  1  one-cycle strobe; in_port valid in the same cycle.

## Operation
- Register map:
  - Addr 0 DATA (read pops): {23'b0, valid, code[7:0]}.
  - Addr 1 STATUS:
    - [0] empty, [1] full, [2] overflow, [3] seq_err, [4] timeout (bits [4:2] sticky, write-1-to-clear).
    - [7:5] FIFO level 0..4.
    - [15:8] sequence-error count, saturating at 255.
    - Writing bit 31 = 1 clears the count.
  - Addr 2 CONTROL (RW): [0] enable, [1] irq_code_en, [2] irq_err_en.
  - Addr 3 RELOAD (RW): [15:0] watchdog reload.
- Capture: on tick_in & enable, push in_port. If full and no pop in the same cycle, drop the new code and set overflow; the FIFO content is unchanged.
- Pop: read at addr 0 with FIFO not empty returns the head with valid = 1 and advances the head. Reading while empty returns 0 and does not change state.
- Simultaneous push and pop: both are performed, level unchanged. Applies when full too, with no overflow.
- Sequence check:
  - have_last flag is cleared at reset and whenever enable = 0. The first captured tick only loads last.
  - On each later tick: if count ≠ (last + 1) mod 64, set seq_err and increment the count (saturating).
  - last is always updated, including on ticks dropped for overflow.
  - Wrap 63 → 0 is legal.
- Watchdog:
  - A 16-bit down-counter loads RELOAD on every captured tick and on the 0 → 1 edge of enable.
  - While enable = 1 and RELOAD ≠ 0, it decrements each cycle. On reaching 0 it sets timeout and reloads.
  - RELOAD = 0 disables the watchdog.
- irq = (irq_code_en & !empty) | (irq_err_en & (overflow | seq_err | timeout)).
- Reset values:
  - readdata = 0, irq = 0.
  - FIFO empty; all sticky bits, count, CONTROL and have_last = 0.
  - RELOAD = TIMEOUT_DEFAULT; watchdog counter = TIMEOUT_DEFAULT.
- Reset mid-operation: FIFO contents discarded, no pending pop effect survives.

## Timing
- Read latency 1: readdata is valid the cycle after read. A pop's effect is visible in STATUS from the next read.
- Push from tick_in shows in level/empty one cycle later. irq follows state with one further register cycle (2 cycles tick → irq).
- Writes take effect the cycle after write.
- W1C vs. same-cycle set: set wins and the bit stays 1.
- Simultaneous count clear and increment: the result is 1.
- Back-to-back tick_in on every cycle is supported.

## Configuration
- SPW_TIMECODE_WATCHDOG_EN defined: watchdog counter and RELOAD register are implemented as above.
- Not defined:
  - No watchdog logic.
  - Addr 3 reads 0 and writes are ignored.
  - STATUS[4] is constant 0 and is excluded from the irq term.
  - TIMEOUT_DEFAULT is unused.

## Test plan
- Enable = 1; ticks with codes 0x05, 0x06, 0x07 → three DATA reads return 0x105, 0x106, 0x107; fourth read returns 0x000; STATUS level 0, empty = 1.
- Six ticks (0x10..0x15), no reads → first four buffered, overflow = 1, level 4, full = 1; reads return 0x110..0x113.
- Ticks 0x3E, 0x3F, 0x00, 0x02 → exactly one seq error (0x00 → 0x02), count = 1. Write 0x8000_0008 to STATUS → seq_err = 0, count = 0.
- RELOAD = 10, enable = 1, no ticks → timeout sets 10–11 cycles after enable. With irq_err_en = 1, irq rises 1 cycle after timeout. Write 0x10 → timeout clears and irq drops.
- FIFO full, tick_in coincident with DATA read → read returns the old head, new code is accepted, overflow stays 0, level stays 4.
- Assert reset with 3 entries buffered and irq high → next cycle irq = 0, STATUS = 0x0000_0001, CONTROL = 0, RELOAD = TIMEOUT_DEFAULT.
